// File: rtl/cic_comb_decimator.sv
// Back half of a CIC decimator: keeps every RATE-th valid sample and runs it through
// NSTAGES pipelined comb stages. The result is truncated to OW bits and qualified by o_aux.

// One comb stage: y = x - x delayed DELAY decimated samples, advanced only when en is high.
module cic_comb_stage #(
  parameter int IW    = 8,
  parameter int DELAY = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          en,
  input  logic [IW-1:0] x,
  output logic [IW-1:0] y
);
  logic [DELAY-1:0][IW-1:0] dl;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dl <= '0;
      y  <= '0;
    end else if (en) begin
      // Modular subtraction; wrap-around is what makes the integrator/comb pair cancel.
      y     <= x - dl[DELAY-1];
      dl[0] <= x;
      for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
    end
  end
endmodule

module cic_comb_decimator #(
  parameter int IW      = 8,
  parameter int OW      = 8,
  parameter int NSTAGES = 3,
  parameter int RATE    = 4,
  parameter int DELAY   = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_data,
  output logic          o_aux
);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  logic [CW-1:0]    cnt;
  logic [IW-1:0]    d0;
  logic [NSTAGES:0] vld_pipe;
  logic [IW-1:0]    s [NSTAGES+1];

  // vld_pipe[k] marks stage k's register as freshly updated; it rides alongside the data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt      <= '0;
      d0       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[NSTAGES-1:0], 1'b0};
      if (i_ce) begin
        if (cnt == CW'(RATE-1)) begin
          cnt         <= '0;
          d0          <= i_data;
          vld_pipe[0] <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign s[0] = d0;

  for (genvar k = 1; k <= NSTAGES; k++) begin : g_comb
    cic_comb_stage #(.IW(IW), .DELAY(DELAY)) u_stage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .en      (vld_pipe[k-1]),
      .x       (s[k-1]),
      .y       (s[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data <= '0;
      o_aux  <= 1'b0;
    end else begin
      o_aux <= vld_pipe[NSTAGES];
      if (vld_pipe[NSTAGES]) o_data <= s[NSTAGES][IW-1 -: OW];
    end
  end
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: three parameterisations checked against a binomial-sum
// reference model every cycle, plus literal expectations for timing, step, wrap, gaps, truncation.
module tb_cic_comb_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ce_a = 0, ce_b = 0, ce_c = 0;
  logic [7:0]  da = '0;
  logic [11:0] db = '0;
  logic [9:0]  dc = '0;
  logic [7:0]  qa, qb;
  logic [5:0]  qc;
  logic        aa, ab, ac;

  cic_comb_decimator #(.IW(8), .OW(8), .NSTAGES(3), .RATE(4), .DELAY(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_ce(ce_a), .i_data(da), .o_data(qa), .o_aux(aa));
  cic_comb_decimator #(.IW(12), .OW(8), .NSTAGES(3), .RATE(1), .DELAY(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_ce(ce_b), .i_data(db), .o_data(qb), .o_aux(ab));
  cic_comb_decimator #(.IW(10), .OW(6), .NSTAGES(2), .RATE(3), .DELAY(2)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_ce(ce_c), .i_data(dc), .o_data(qc), .o_aux(ac));

  localparam int PIW[3] = '{8, 12, 10};
  localparam int POW[3] = '{8, 8, 6};
  localparam int PN[3]  = '{3, 3, 2};
  localparam int PR[3]  = '{4, 1, 3};
  localparam int PD[3]  = '{1, 1, 2};

  int passes = 0;
  int checks = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: output n = sum_j (-1)^j C(N,j) x[n-j*D] mod 2^IW, zero history before reset.
  int e = 0;
  int cnt[3];
  int nx[3];
  int xs[3][8192];
  int due_e[3][16];
  int due_v[3][16];
  int hd[3];
  int tl[3];
  int held[3];

  function automatic int comb_ref(int k);
    int acc = 0;
    int c = 1;
    int n = nx[k] - 1;
    for (int j = 0; j <= PN[k]; j++) begin
      if (n - j*PD[k] >= 0) acc += ((j % 2) ? -c : c) * xs[k][n - j*PD[k]];
      c = c * (PN[k] - j) / (j + 1);
    end
    acc = acc & ((1 << PIW[k]) - 1);
    return acc >> (PIW[k] - POW[k]);
  endfunction

  function automatic int ce_of(int k);
    return (k == 0) ? int'(ce_a) : (k == 1) ? int'(ce_b) : int'(ce_c);
  endfunction

  function automatic int x_of(int k);
    return (k == 0) ? int'(da) : (k == 1) ? int'(db) : int'(dc);
  endfunction

  function automatic int q_of(int k);
    return (k == 0) ? int'(qa) : (k == 1) ? int'(qb) : int'(qc);
  endfunction

  function automatic int a_of(int k);
    return (k == 0) ? int'(aa) : (k == 1) ? int'(ab) : int'(ac);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; nx[k] = 0; hd[k] = 0; tl[k] = 0; held[k] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      e++;
      if (rst) model_reset();
      else for (int k = 0; k < 3; k++) begin
        if (ce_of(k) != 0) begin
          cnt[k]++;
          if (cnt[k] == PR[k]) begin
            cnt[k] = 0;
            xs[k][nx[k]] = x_of(k);
            nx[k]++;
            due_e[k][tl[k]] = e + PN[k] + 1;
            due_v[k][tl[k]] = comb_ref(k);
            tl[k] = (tl[k] + 1) % 16;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rst_aux%0d", k), a_of(k), 0);
          chk($sformatf("rst_data%0d", k), q_of(k), 0);
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          int ea;
          ea = (hd[k] != tl[k] && due_e[k][hd[k]] == e) ? 1 : 0;
          if (ea != 0) begin
            held[k] = due_v[k][hd[k]];
            hd[k] = (hd[k] + 1) % 16;
          end
          chk($sformatf("aux%0d", k), a_of(k), ea);
          chk($sformatf("data%0d", k), q_of(k), held[k]);
        end
      end
    end
  end

  int la[64], ld[64], lb[64], lbd[64];

  task automatic log_edge(int k);
    @(negedge clk);
    la[k] = int'(aa); ld[k] = int'(qa); lb[k] = int'(ab); lbd[k] = int'(qb);
    #1;
  endtask

  task automatic do_reset();
    ce_a = 0; ce_b = 0; ce_c = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("init_aux", int'(aa), 0);
    chk("init_data", int'(qa), 0);
    #1 rst = 0;

    // Ramp: captures 3,7,11; outputs 3 then 7-3*3 = -2.
    for (int k = 1; k <= 13; k++) begin
      ce_a = 1; da = 8'(k - 1);
      log_edge(k);
    end
    chk("ramp_pre", la[7], 0);
    chk("ramp_first_aux", la[8], 1);
    chk("ramp_first_data", ld[8], 8'h03);
    chk("ramp_gap", la[11], 0);
    chk("ramp_second_aux", la[12], 1);
    chk("ramp_second_data", ld[12], 8'hFE);

    // Asynchronous reset in the middle of a cycle with a sample in flight.
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_aux", int'(aa), 0);
    chk("async_rst_data", int'(qa), 0);
    ce_a = 0;
    @(negedge clk);
    #1 rst = 0;

    // Step of 5 on A, step of 0x150 on B (12-bit in, top 8 bits out, RATE=1).
    for (int k = 1; k <= 20; k++) begin
      ce_a = 1; da = 8'd5; ce_b = 1; db = 12'h150;
      log_edge(k);
    end
    chk("step_pre", la[7], 0);
    chk("step_first_aux", la[8], 1);
    chk("step_d0", ld[8], 8'h05);
    chk("step_d1", ld[12], 8'hF6);
    chk("step_d2", ld[16], 8'h05);
    chk("step_d3", ld[20], 8'h00);
    chk("trunc_pre", lb[4], 0);
    chk("trunc_d0", lbd[5], 8'h15);
    chk("trunc_d1", lbd[6], 8'hD6);
    chk("trunc_d2", lbd[7], 8'h15);
    chk("trunc_d3", lbd[8], 8'h00);
    n = 0;
    for (int k = 5; k <= 20; k++) n += lb[k];
    chk("rate1_continuous", n, 16);
    do_reset();

    // Wrap: decimated 0x7F then 0x80.
    for (int k = 1; k <= 12; k++) begin
      ce_a = 1; da = (k <= 4) ? 8'h7F : 8'h80;
      log_edge(k);
    end
    chk("wrap_d0", ld[8], 8'h7F);
    chk("wrap_d1", ld[12], 8'h03);
    do_reset();

    // Gapped ce: every 3rd clock.
    for (int k = 1; k <= 40; k++) begin
      ce_a = (k % 3 == 1); da = 8'd5;
      log_edge(k);
    end
    chk("gap_pre", la[13], 0);
    chk("gap_first_aux", la[14], 1);
    chk("gap_d0", ld[14], 8'h05);
    chk("gap_hold", ld[20], 8'h05);
    chk("gap_second_aux", la[26], 1);
    chk("gap_d1", ld[26], 8'hF6);
    chk("gap_d2", ld[38], 8'h05);
    n = 0;
    for (int k = 1; k <= 40; k++) n += la[k];
    chk("gap_count", n, 3);
    do_reset();

    // Randomised traffic on all three configurations with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 4;
      ce_a = ($urandom_range(0, 3) >= dens);
      ce_b = ($urandom_range(0, 3) >= dens);
      ce_c = ($urandom_range(0, 3) >= dens);
      da = 8'($urandom);
      db = 12'($urandom);
      dc = 10'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      #1;
    end
    rst = 0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
